player_anim_ctrl: RTL
=====================

PLAYER_ANIM_CTRL -- requirements
Module: player_anim_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- FRAME_TICKS, 15_000_000, clk cycles per animation frame (>=2)
- WALK_FRAMES, 2, walk-cycle frames (2..8)
- PUNCH_FRAMES, 3, punch frames (1..8)
- KICK_FRAMES, 3, kick frames (1..8)
- PIX_W, 12, pixel width, RGB 4:4:4
REQ-002 Derived constant NUM_FRAMES = 1+WALK_FRAMES+PUNCH_FRAMES+KICK_FRAMES; FID_W = clog2(NUM_FRAMES).
REQ-003 Ports SHALL be, one per line: name direction width meaning.
- clk  in  1  system clock, single clock domain
- rst  in  1  asynchronous, active-high reset
- player_inputs  in  7  [1]=left, [2]=right, [3]=punch, [4]=kick, others ignored
- frame_pixels  in  NUM_FRAMES*PIX_W  current pixel of every frame ROM, frame k at [k*PIX_W +: PIX_W]
- pixel_data  out  PIX_W  registered pixel of selected frame
- frame_id  out  FID_W  selected frame index
- anim_state  out  2  0=IDLE, 1=WALK, 2=PUNCH, 3=KICK
- attack_active  out  1  high in PUNCH or KICK
- anim_done  out  1  one-cycle pulse on attack completion

Function
REQ-004 Frame map SHALL be: 0=standing; 1..WALK_FRAMES=walk; next PUNCH_FRAMES=punch; next KICK_FRAMES=kick.
REQ-005 A tick counter SHALL count 0..FRAME_TICKS-1 and assert an internal one-cycle tick at FRAME_TICKS-1, then wrap to 0; no derived clocks.
REQ-006 walk_req SHALL be left XOR right; left AND right together SHALL count as no walk.
REQ-007 Attack triggers SHALL be rising edges of punch/kick, detected against a registered previous value; held buttons SHALL NOT retrigger.
REQ-008 IDLE/WALK: punch edge -> PUNCH; else kick edge -> KICK (punch wins if simultaneous); else walk_req selects WALK, otherwise IDLE.
REQ-009 WALK SHALL advance walk frame index on each tick, wrapping WALK_FRAMES-1 -> 0; index SHALL reset to 0 whenever WALK is left.
REQ-010 Entering PUNCH/KICK SHALL clear the tick counter and attack frame index to 0, so the first frame lasts exactly FRAME_TICKS cycles.
REQ-011 In PUNCH/KICK, each tick advances the frame; tick on last frame SHALL exit to WALK if walk_req else IDLE and pulse anim_done for that cycle.
REQ-012 Attack edges and walk changes during an attack SHALL be ignored (no queuing); attack is non-interruptible except by rst.
REQ-013 frame_id, anim_state, attack_active SHALL be registered and consistent in the same cycle.
REQ-014 pixel_data SHALL equal frame_pixels slice at frame_id, registered: one clk latency from frame_id.
REQ-015 Tick counter SHALL free-run in IDLE/WALK (not cleared on IDLE<->WALK).

Reset
REQ-016 rst SHALL asynchronously force: state IDLE, frame_id 0, pixel_data 0, attack_active 0, anim_done 0, tick counter 0, frame indices 0, edge registers 0.
REQ-017 rst asserted mid-attack SHALL abort it without anim_done; after release a still-held button SHALL NOT trigger (edge register cleared to 0 then loads held value — first cycle after release counts as an edge only if button rises afterwards; implement by loading edge register from inputs while rst high).

Structure
REQ-018 A shared package SHALL hold the anim_state encoding and the frame-map base-offset functions.
REQ-019 The tick counter SHALL be one sub-module, anim_tick_gen (parameter FRAME_TICKS, outputs tick).
REQ-020 Target size 120-400 lines RTL; no ROMs inside this block.

Verification (FRAME_TICKS=4, defaults otherwise)
REQ-021 Reset then idle 20 cycles -> frame_id=0, anim_state=0, pixel_data=frame 0 pixel one cycle after.
REQ-022 Hold right 20 cycles -> anim_state=1, frame_id toggles 1,2,1,2 every 4 cycles; left+right -> frame_id=0.
REQ-023 Pulse punch 1 cycle -> frame_id 3,4,5 each 4 cycles, anim_done pulse at exit, state IDLE.
REQ-024 Punch and kick rise same cycle -> PUNCH only; kick edge during punch -> ignored, no KICK afterwards.
REQ-025 Kick while holding right -> frames 6,7,8 then WALK at frame_id 1.
REQ-026 rst during frame 4 of punch -> all outputs 0 immediately, no anim_done; held punch after release -> stays IDLE.

Source files
------------

// File: rtl/player_anim_ctrl_pkg.sv
// Shared definitions for the player sprite animation controller:
// state encoding, button bit positions and frame-map base offsets.
package player_anim_ctrl_pkg;

    typedef enum logic [1:0] {
        ANIM_IDLE  = 2'd0,
        ANIM_WALK  = 2'd1,
        ANIM_PUNCH = 2'd2,
        ANIM_KICK  = 2'd3
    } anim_state_t;

    localparam int unsigned BTN_LEFT  = 1;
    localparam int unsigned BTN_RIGHT = 2;
    localparam int unsigned BTN_PUNCH = 3;
    localparam int unsigned BTN_KICK  = 4;

    localparam int unsigned STAND_FRAME = 0;

    function automatic int unsigned walk_base();
        return STAND_FRAME + 1;
    endfunction

    function automatic int unsigned punch_base(input int unsigned walk_frames);
        return walk_base() + walk_frames;
    endfunction

    function automatic int unsigned kick_base(input int unsigned walk_frames,
                                              input int unsigned punch_frames);
        return punch_base(walk_frames) + punch_frames;
    endfunction

endpackage

// File: rtl/anim_tick_gen.sv
// Frame-rate tick generator: counts 0..FRAME_TICKS-1 and flags the last count.
// A synchronous clear restarts the frame period from zero.
module anim_tick_gen #(
    parameter int unsigned FRAME_TICKS = 15_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clear || tick)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/player_anim_ctrl.sv
// Player sprite animation controller: selects idle/walk/punch/kick frames
// from button inputs and forwards the matching frame ROM pixel.
module player_anim_ctrl
    import player_anim_ctrl_pkg::*;
#(
    parameter int unsigned FRAME_TICKS  = 15_000_000,
    parameter int unsigned WALK_FRAMES  = 2,
    parameter int unsigned PUNCH_FRAMES = 3,
    parameter int unsigned KICK_FRAMES  = 3,
    parameter int unsigned PIX_W        = 12,
    localparam int unsigned NUM_FRAMES  = 1 + WALK_FRAMES + PUNCH_FRAMES + KICK_FRAMES,
    localparam int unsigned FID_W       = $clog2(NUM_FRAMES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [6:0]                  player_inputs,
    input  logic [NUM_FRAMES*PIX_W-1:0] frame_pixels,
    output logic [PIX_W-1:0]            pixel_data,
    output logic [FID_W-1:0]            frame_id,
    output logic [1:0]                  anim_state,
    output logic                        attack_active,
    output logic                        anim_done
);

    localparam int unsigned IDX_W      = 3;
    localparam int unsigned WALK_BASE  = walk_base();
    localparam int unsigned PUNCH_BASE = punch_base(WALK_FRAMES);
    localparam int unsigned KICK_BASE  = kick_base(WALK_FRAMES, PUNCH_FRAMES);
    localparam logic [IDX_W-1:0] WALK_LAST  = IDX_W'(WALK_FRAMES - 1);
    localparam logic [IDX_W-1:0] PUNCH_LAST = IDX_W'(PUNCH_FRAMES - 1);
    localparam logic [IDX_W-1:0] KICK_LAST  = IDX_W'(KICK_FRAMES - 1);

    anim_state_t       state_q, state_d;
    logic [IDX_W-1:0]  walk_q, walk_d, atk_q, atk_d;
    logic [FID_W-1:0]  frame_id_q, fid_d;
    logic [PIX_W-1:0]  pixel_q, pix_sel;
    logic              attack_q, done_q, done_d;
    logic              prev_punch, prev_kick, rst_q;
    logic              tick, clear;
    logic              walk_req, punch_edge, kick_edge;
    logic              unused_btns;

    assign unused_btns = ^{player_inputs[6:5], player_inputs[0]};

    assign walk_req = player_inputs[BTN_LEFT] ^ player_inputs[BTN_RIGHT];
    // rst_q masks the first cycle after reset so a button held through reset
    // is loaded into the edge register instead of being seen as a new press.
    assign punch_edge = player_inputs[BTN_PUNCH] & ~prev_punch & ~rst_q;
    assign kick_edge  = player_inputs[BTN_KICK]  & ~prev_kick  & ~rst_q;

    anim_tick_gen #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        walk_d  = walk_q;
        atk_d   = atk_q;
        clear   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ANIM_IDLE, ANIM_WALK: begin
                if (punch_edge || kick_edge) begin
                    state_d = punch_edge ? ANIM_PUNCH : ANIM_KICK;
                    walk_d  = '0;
                    atk_d   = '0;
                    clear   = 1'b1;
                end else if (walk_req) begin
                    state_d = ANIM_WALK;
                    if (state_q == ANIM_WALK && tick)
                        walk_d = (walk_q == WALK_LAST) ? '0 : walk_q + IDX_W'(1);
                end else begin
                    state_d = ANIM_IDLE;
                    walk_d  = '0;
                end
            end
            default: begin
                if (tick) begin
                    if (atk_q == ((state_q == ANIM_PUNCH) ? PUNCH_LAST : KICK_LAST)) begin
                        state_d = walk_req ? ANIM_WALK : ANIM_IDLE;
                        atk_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        atk_d = atk_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (state_d)
            ANIM_WALK:  fid_d = FID_W'(WALK_BASE  + 32'(walk_d));
            ANIM_PUNCH: fid_d = FID_W'(PUNCH_BASE + 32'(atk_d));
            ANIM_KICK:  fid_d = FID_W'(KICK_BASE  + 32'(atk_d));
            default:    fid_d = FID_W'(STAND_FRAME);
        endcase
    end

    always_comb begin
        pix_sel = '0;
        for (int unsigned k = 0; k < NUM_FRAMES; k++)
            if (frame_id_q == FID_W'(k))
                pix_sel = frame_pixels[k*PIX_W +: PIX_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ANIM_IDLE;
            walk_q     <= '0;
            atk_q      <= '0;
            frame_id_q <= '0;
            attack_q   <= 1'b0;
            done_q     <= 1'b0;
            pixel_q    <= '0;
            prev_punch <= 1'b0;
            prev_kick  <= 1'b0;
            rst_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            walk_q     <= walk_d;
            atk_q      <= atk_d;
            frame_id_q <= fid_d;
            attack_q   <= (state_d == ANIM_PUNCH) || (state_d == ANIM_KICK);
            done_q     <= done_d;
            pixel_q    <= pix_sel;
            prev_punch <= player_inputs[BTN_PUNCH];
            prev_kick  <= player_inputs[BTN_KICK];
            rst_q      <= 1'b0;
        end
    end

    assign pixel_data    = pixel_q;
    assign frame_id      = frame_id_q;
    assign anim_state    = state_q;
    assign attack_active = attack_q;
    assign anim_done     = done_q;

endmodule
